lcd_frame_sched: RTL and testbench

Frame scheduler and bus arbiter for the ILI9341 8-bit write path. It shares one byte-wide command/data channel between host command bytes and full-frame pixel refreshes. It synchronises frame starts to the panel tearing-effect line (fmark). Each frame is sequenced as window setup, then RAMWR, then WIDTH×HEIGHT RGB565 pixels. It sits between the pixel source (framebuffer reader) and the byte-level bus writer that toggles lcd_we_n.

---
 rtl/lcd_frame_sched.sv | 209 ++++++++++++++++++++
 tb/tb_lcd_frame_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sched.sv
// lcd_frame_sched: frame scheduler and byte-bus arbiter for the ILI9341
// 8-bit write path. Interleaves host command/parameter bytes with full-frame
// refreshes (CASET/PASET window, RAMWR, then WIDTH*HEIGHT RGB565 pixels).
//
// Build option: LCD_SCHED_TE_SYNC_EN
//   defined   - frames start on the rising edge of the synchronised lcd_fmark.
//   undefined - lcd_fmark is ignored and refresh is free-running.
module lcd_frame_sched #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_fmark,
    input  logic        refresh_en,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_rs,
    input  logic [7:0]  host_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_rs,
    output logic [7:0]  bus_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HOST      = 3'd1;
    localparam logic [2:0] S_WAIT_TE   = 3'd2;
    localparam logic [2:0] S_WIN       = 3'd3;
    localparam logic [2:0] S_PIX_FETCH = 3'd4;
    localparam logic [2:0] S_PIX_HI    = 3'd5;
    localparam logic [2:0] S_PIX_LO    = 3'd6;

    localparam logic [15:0] COL_END  = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_END  = 16'(HEIGHT - 1);
    localparam logic [16:0] PIX_LAST = 17'(WIDTH * HEIGHT - 1);
    localparam logic [3:0]  WIN_LAST = 4'd10;

    logic [2:0]  r_state;
    logic        r_prev_lo;     // previous cycle was PIX_LO: host gets one slot
    logic        r_bus_valid;
    logic        r_bus_rs;
    logic [7:0]  r_bus_data;
    logic [3:0]  r_win_idx;
    logic [16:0] r_pix_cnt;
    logic [7:0]  r_pix_lo;
    logic        r_frame_start;

    logic        w_bus_acc;
    logic        w_te_go;
    logic        w_last_pix;

    // Window setup byte table, returned as {rs, data}.
    function automatic logic [8:0] win_byte(input logic [3:0] idx);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, 8'h00};
            4'd2:    b = {1'b1, 8'h00};
            4'd3:    b = {1'b1, COL_END[15:8]};
            4'd4:    b = {1'b1, COL_END[7:0]};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, 8'h00};
            4'd7:    b = {1'b1, 8'h00};
            4'd8:    b = {1'b1, ROW_END[15:8]};
            4'd9:    b = {1'b1, ROW_END[7:0]};
            4'd10:   b = {1'b0, 8'h2C};
            default: b = {1'b0, 8'h00};
        endcase
        return b;
    endfunction

`ifdef LCD_SCHED_TE_SYNC_EN
    logic r_te_s1;
    logic r_te_s2;
    logic r_te_prev;
    logic r_te_edge;

    // Two-flop synchroniser for the async TE pin, then a registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_te_s1   <= 1'b0;
            r_te_s2   <= 1'b0;
            r_te_prev <= 1'b0;
            r_te_edge <= 1'b0;
        end else begin
            r_te_s1   <= lcd_fmark;
            r_te_s2   <= r_te_s1;
            r_te_prev <= r_te_s2;
            r_te_edge <= r_te_s2 & ~r_te_prev;
        end
    end

    // The edge pulse is only looked at in WAIT_TE, so edges elsewhere are dropped.
    assign w_te_go = r_te_edge;
`else
    logic w_unused_fmark;
    assign w_unused_fmark = lcd_fmark;
    assign w_te_go        = 1'b1;
`endif

    assign w_bus_acc  = r_bus_valid & bus_ready;
    assign w_last_pix = (r_pix_cnt == PIX_LAST);

    // Main sequencer: arbitration, window bytes, pixel byte split, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_prev_lo     <= 1'b0;
            r_bus_valid   <= 1'b0;
            r_bus_rs      <= 1'b0;
            r_bus_data    <= 8'h00;
            r_win_idx     <= 4'd0;
            r_pix_cnt     <= 17'd0;
            r_pix_lo      <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_prev_lo     <= (r_state == S_PIX_LO);
            case (r_state)
                S_IDLE: begin
                    // Refresh wins, except the one host slot right after a frame.
                    if (host_valid && (!refresh_en || r_prev_lo))
                        r_state <= S_HOST;
                    else if (refresh_en)
                        r_state <= S_WAIT_TE;
                end
                S_HOST: begin
                    if (!r_bus_valid) begin
                        if (host_valid) begin
                            r_bus_valid <= 1'b1;
                            r_bus_rs    <= host_rs;
                            r_bus_data  <= host_data;
                        end
                    end else if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_WAIT_TE: begin
                    if (!refresh_en) begin
                        r_state <= S_IDLE;
                    end else if (w_te_go) begin
                        {r_bus_rs, r_bus_data} <= win_byte(4'd0);
                        r_bus_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_win_idx     <= 4'd0;
                        r_state       <= S_WIN;
                    end
                end
                S_WIN: begin
                    if (w_bus_acc) begin
                        if (r_win_idx == WIN_LAST) begin
                            r_bus_valid <= 1'b0;
                            r_state     <= S_PIX_FETCH;
                        end else begin
                            r_win_idx              <= r_win_idx + 4'd1;
                            {r_bus_rs, r_bus_data} <= win_byte(r_win_idx + 4'd1);
                        end
                    end
                end
                S_PIX_FETCH: begin
                    if (pix_valid) begin
                        r_pix_lo    <= pix_data[7:0];
                        r_bus_rs    <= 1'b1;
                        r_bus_data  <= pix_data[15:8];
                        r_bus_valid <= 1'b1;
                        r_state     <= S_PIX_HI;
                    end
                end
                S_PIX_HI: begin
                    if (w_bus_acc) begin
                        r_bus_data <= r_pix_lo;
                        r_state    <= S_PIX_LO;
                    end
                end
                S_PIX_LO: begin
                    if (w_bus_acc) begin
                        r_bus_valid <= 1'b0;
                        if (w_last_pix) begin
                            r_pix_cnt <= 17'd0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 17'd1;
                            r_state   <= S_PIX_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_ready  = (r_state == S_HOST) && !r_bus_valid;
    assign pix_ready   = (r_state == S_PIX_FETCH);
    assign bus_valid   = r_bus_valid;
    assign bus_rs      = r_bus_rs;
    assign bus_data    = r_bus_data;
    assign frame_start = r_frame_start;
    assign frame_done  = (r_state == S_PIX_LO) && w_bus_acc && w_last_pix;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Bench for lcd_frame_sched with a 4x2 panel: host byte table, window/pixel
// stream against a byte-stream model, random stalls, host arbitration,
// mid-frame reset and back-to-back free-running restart.
module tb_lcd_frame_sched;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int TMO  = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_fmark;
    logic        refresh_en;
    logic        host_valid, host_ready, host_rs;
    logic [7:0]  host_data;
    logic        pix_valid, pix_ready;
    logic [15:0] pix_data;
    logic        bus_valid, bus_ready, bus_rs;
    logic [7:0]  bus_data;
    logic        frame_start, frame_done, busy;

    lcd_frame_sched #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .lcd_fmark(lcd_fmark), .refresh_en(refresh_en),
        .host_valid(host_valid), .host_ready(host_ready), .host_rs(host_rs), .host_data(host_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rs(bus_rs), .bus_data(bus_data),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int vecs = 0, miss = 0, cyc = 0;
    logic [8:0]  acc_q[$];
    logic [8:0]  exp_q[$];
    logic [15:0] pv[256];
    int sp, pidx = 0;
    int fs_cnt = 0, fd_cnt = 0, fs_cyc = 0, fd_cyc = 0, fd_at = 0;
    int host_acc = 0, bad_host = 0;
    bit in_frame = 0, len_mode = 0, gap_mode = 0;
    bit stall_bus = 0, stall_pix = 0, pix_en = 1, pix_taken = 0;
    bit stall_prev = 0;
    logic [9:0] held;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic       exp_rs;
        logic [7:0] exp_d;
    } hvec_t;
    hvec_t htab[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vecs++; miss++;
        $display("FAIL %s: timeout", nm);
    endtask

    // Monitor: samples on the falling edge, logs accepted bytes and pulses.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 0;
            in_frame   = 0;
        end else begin
            if (stall_prev) chk("stall_hold", {bus_valid, bus_rs, bus_data}, held);
            stall_prev = bus_valid && !bus_ready;
            held = {1'b1, bus_rs, bus_data};
            if (bus_valid && bus_ready) acc_q.push_back({bus_rs, bus_data});
            if (pix_valid && pix_ready) pix_taken = 1;
            if (host_valid && host_ready) host_acc++;
            if (host_ready && in_frame) bad_host++;
            if (frame_start) begin
                fs_cnt++;
                in_frame = 1;
                chk("frame_start_byte", {bus_valid, bus_rs, bus_data}, {1'b1, 1'b0, 8'h2A});
                if (gap_mode) chk("restart_gap", cyc - fd_cyc, 3);
                fs_cyc = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                in_frame = 0;
                fd_cyc = cyc;
                fd_at = acc_q.size();
                chk("frame_done_on_accept", {bus_valid, bus_ready, bus_rs}, 3'b111);
                if (len_mode) chk("frame_len", cyc - fs_cyc, 11 + 3 * NPIX - 1);
            end
        end
    end

    // Pixel source and downstream sink, driven just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (pix_taken) begin pidx++; pix_taken = 0; end
        pix_data  = pv[pidx % 256];
        pix_valid = pix_en && (!stall_pix || ($urandom % 3 != 0));
        bus_ready = !stall_bus || ($urandom % 2 == 0);
    end

`ifdef LCD_SCHED_TE_SYNC_EN
    initial begin
        lcd_fmark = 1'b0;
        forever begin
            repeat (60) @(posedge clk);
            #2 lcd_fmark = 1'b1;
            repeat (3) @(posedge clk);
            #2 lcd_fmark = 1'b0;
        end
    end
`else
    initial lcd_fmark = 1'b0;
`endif

    // Reference model: the byte stream a frame or host byte must produce.
    task automatic add_frame();
        logic [15:0] ce, re, p;
        ce = 16'(W - 1);
        re = 16'(H - 1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, ce[15:8]}); exp_q.push_back({1'b1, ce[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, re[15:8]}); exp_q.push_back({1'b1, re[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < NPIX; i++) begin
            p = pv[sp % 256];
            sp++;
            exp_q.push_back({1'b1, p[15:8]});
            exp_q.push_back({1'b1, p[7:0]});
        end
    endtask

    task automatic cmp_stream(input string nm);
        int bad;
        bad = -1;
        chk({nm, "_len"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            if (bad < 0 && acc_q[i] !== exp_q[i]) bad = i;
        vecs++;
        if (bad >= 0) begin
            miss++;
            $display("FAIL %s byte %0d: got %h want %h", nm, bad, acc_q[bad], exp_q[bad]);
        end
    endtask

    task automatic wait_fs(input int n, input string nm);
        int t = 0;
        while (fs_cnt < n && t < TMO) begin @(negedge clk); t++; end
        if (fs_cnt < n) timeout(nm);
    endtask

    task automatic wait_fd(input int n, input string nm);
        int t = 0;
        while (fd_cnt < n && t < TMO) begin @(negedge clk); t++; end
        if (fd_cnt < n) timeout(nm);
    endtask

    task automatic wait_host(input int n, input string nm);
        int t = 0;
        while (host_acc < n && t < TMO) begin @(negedge clk); t++; end
        if (host_acc < n) timeout(nm);
    endtask

    task automatic start_test();
        @(negedge clk);
        acc_q.delete();
        exp_q.delete();
        sp = pidx;
    endtask

    initial begin
        int fs0, fd0, h0, p0, t;
        rst = 1'b1; refresh_en = 1'b0;
        host_valid = 1'b0; host_rs = 1'b0; host_data = 8'h00;
        for (int i = 0; i < 256; i++)
            pv[i] = (i < NPIX) ? 16'(16'h1234 + i * 16'h0101) : 16'($urandom);
        htab[0] = '{1'b0, 8'h36, 1'b0, 8'h36};
        htab[1] = '{1'b1, 8'h48, 1'b1, 8'h48};
        htab[2] = '{1'b0, 8'h11, 1'b0, 8'h11};
        htab[3] = '{1'b1, 8'hFF, 1'b1, 8'hFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_rs", bus_rs, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Host bytes with refresh off
        p0 = pidx;
        fs0 = fs_cnt;
        for (int i = 0; i < 4; i++) begin
            start_test();
            host_rs = htab[i].rs; host_data = htab[i].d; host_valid = 1'b1;
            t = 0;
            while (!host_ready && t < 50) begin @(negedge clk); t++; end
            if (!host_ready) timeout("host_accept");
            @(posedge clk); #1 host_valid = 1'b0;
            @(negedge clk);
            chk("host_latency", bus_valid, 1);
            repeat (3) @(negedge clk);
            chk("host_byte", acc_q.size() > 0 ? acc_q[0] : 9'h1FF, {htab[i].exp_rs, htab[i].exp_d});
            chk("host_one_byte", acc_q.size(), 1);
            chk("host_busy_clear", busy, 0);
        end
        chk("host_no_frame", fs_cnt - fs0, 0);
        chk("host_no_pixels", pidx - p0, 0);

        // Single frame, no stalls; refresh dropped mid-frame
        start_test();
        fs0 = fs_cnt; fd0 = fd_cnt; len_mode = 1;
        refresh_en = 1'b1;
        wait_fs(fs0 + 1, "frame1_start");
        refresh_en = 1'b0;
        wait_fd(fd0 + 1, "frame1_done");
        repeat (10) @(negedge clk);
        add_frame();
        cmp_stream("frame1");
        chk("done_at_last_byte", fd_at, 11 + 2 * NPIX);
        chk("frame1_count", fd_cnt - fd0, 1);
        chk("frame1_idle", busy, 0);
        len_mode = 0;

        // Two frames under random bus and pixel stalls
        start_test();
        fs0 = fs_cnt; fd0 = fd_cnt;
        stall_bus = 1; stall_pix = 1;
        refresh_en = 1'b1;
        wait_fs(fs0 + 2, "stall_start");
        refresh_en = 1'b0;
        wait_fd(fd0 + 2, "stall_done");
        stall_bus = 0; stall_pix = 0;
        repeat (10) @(negedge clk);
        add_frame();
        add_frame();
        cmp_stream("stall");

        // Host held during continuous refresh: one byte per frame gap
        start_test();
        fs0 = fs_cnt; fd0 = fd_cnt; h0 = host_acc; bad_host = 0; len_mode = 1;
        refresh_en = 1'b1;
        wait_fs(fs0 + 1, "arb_start");
        host_rs = 1'b1; host_data = 8'h55; host_valid = 1'b1;
        wait_host(h0 + 1, "arb_host1");
        chk("arb_gap1", {fs_cnt - fs0, fd_cnt - fd0}, {32'd1, 32'd1});
        wait_host(h0 + 2, "arb_host2");
        chk("arb_gap2", {fs_cnt - fs0, fd_cnt - fd0}, {32'd2, 32'd2});
        @(posedge clk); #1;
        host_valid = 1'b0; refresh_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("arb_host_count", host_acc - h0, 2);
        chk("arb_ready_in_frame", bad_host, 0);
        add_frame();
        exp_q.push_back({1'b1, 8'h55});
        add_frame();
        exp_q.push_back({1'b1, 8'h55});
        cmp_stream("arb");
        len_mode = 0;

        // Reset while a pixel high byte is on the bus
        start_test();
        refresh_en = 1'b1;
        t = 0;
        while (!(acc_q.size() >= 11 && bus_valid && bus_rs) && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) timeout("rst_reach_pix_hi");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", bus_valid, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        acc_q.delete();
        exp_q.delete();
        sp = pidx;
        fs0 = fs_cnt; fd0 = fd_cnt;
        wait_fs(fs0 + 1, "rst_restart");
        refresh_en = 1'b0;
        wait_fd(fd0 + 1, "rst_done");
        repeat (10) @(negedge clk);
        add_frame();
        cmp_stream("rst_frame");

`ifndef LCD_SCHED_TE_SYNC_EN
        // Free-running back-to-back frames
        start_test();
        fs0 = fs_cnt; fd0 = fd_cnt;
        refresh_en = 1'b1;
        wait_fs(fs0 + 1, "b2b_first");
        gap_mode = 1;
        wait_fs(fs0 + 3, "b2b_next");
        refresh_en = 1'b0;
        wait_fd(fd0 + 3, "b2b_done");
        gap_mode = 0;
        repeat (10) @(negedge clk);
        add_frame(); add_frame(); add_frame();
        cmp_stream("b2b");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
